// File: rtl/riscv_nn_apu_disp_pkg.sv
// Shared types for the APU dispatcher.
//   apu_lat_e   : latency class of an APU operation
//   lat_conflict: true when a new op of class new_lat may not issue behind
//                 outstanding ops last issued with class last_lat, because
//                 its result could come back out of issue order.
package riscv_nn_apu_disp_pkg;

   typedef enum logic [1:0] {
      LAT_MULTI  = 2'd0,
      LAT_SINGLE = 2'd1,
      LAT_TWO    = 2'd2,
      LAT_LONG   = 2'd3
   } apu_lat_e;

   function automatic logic lat_conflict(input apu_lat_e new_lat, input apu_lat_e last_lat);
      return (new_lat == LAT_MULTI) || (last_lat == LAT_MULTI) ||
             (new_lat < last_lat)   || (new_lat == LAT_SINGLE);
   endfunction

endpackage

// File: rtl/riscv_nn_apu_inflight_queue.sv
// In-flight queue of destination addresses for outstanding APU requests.
// Circular buffer with a per-entry valid vector; results return in issue order.
//   clk_i, rst_ni : clock, async active-low reset (drops all entries)
//   push_i        : write waddr_i at the tail
//   pop_i         : retire the head entry
//   waddr_i       : destination address of the pushed request
//   head_addr_o   : destination address of the oldest entry
//   count_o       : number of valid entries
//   live_o        : per-entry valid, with the head masked off while it pops
//   addr_o        : per-entry stored address, for dependency compare
module riscv_nn_apu_inflight_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 6
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [ADDR_W-1:0]             waddr_i,
   output logic [ADDR_W-1:0]             head_addr_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic [DEPTH-1:0]              live_o,
   output logic [DEPTH-1:0][ADDR_W-1:0]  addr_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
   logic [DEPTH-1:0]             r_vld;
   logic [PTR_W-1:0]             r_wr;
   logic [PTR_W-1:0]             r_rd;
   logic [PTR_W:0]               r_cnt;

   // Pointers wrap naturally since DEPTH is a power of two. The caller never
   // pushes when full nor pops when empty, so a simultaneous push and pop
   // always touch different slots.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem <= '0;
         r_vld <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (pop_i) begin
            r_vld[r_rd] <= 1'b0;
            r_rd        <= r_rd + 1'b1;
         end
         if (push_i) begin
            r_vld[r_wr] <= 1'b1;
            r_mem[r_wr] <= waddr_i;
            r_wr        <= r_wr + 1'b1;
         end
         if (push_i && !pop_i)
            r_cnt <= r_cnt + 1'b1;
         else if (pop_i && !push_i)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   // A popping head is writing back this cycle, so it no longer blocks ID.
   always_comb begin
      live_o = r_vld;
      if (pop_i)
         live_o[r_rd] = 1'b0;
   end

   assign head_addr_o = r_mem[r_rd];
   assign count_o     = r_cnt;
   assign addr_o      = r_mem;

endmodule

// File: rtl/riscv_nn_apu_disp_mq.sv
// APU dispatcher with a DEPTH-entry in-flight queue.
// Issues requests from EX to the APU interconnect, stalls when latency
// classes could reorder results, when the queue is full or when the grant is
// withheld, flags RAW/WAW hazards in ID against outstanding destinations, and
// drives the writeback address for each returning response.
//   clk_i, rst_ni                      : clock, async active-low reset
//   enable_i, apu_lat_i, apu_waddr_i   : new APU request from EX
//   apu_waddr_o, apu_wvalid_o          : writeback of returning result
//   apu_multicycle_o/singlecycle_o     : pipeline hints
//   active_o, count_o, stall_o         : queue status and EX stall
//   is_decoding_i, read_/write_regs_*  : ID operands for hazard check
//   read_dep_o, write_dep_o            : RAW / WAW hazard
//   perf_type_o/cont_o/full_o          : stall cause breakdown
//   err_o                              : sticky unexpected response
//   apu_master_*                       : interconnect handshake
module riscv_nn_apu_disp_mq
   import riscv_nn_apu_disp_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 6,
   parameter int N_RD   = 3,
   parameter int N_WR   = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic [1:0]               apu_lat_i,
   input  logic [ADDR_W-1:0]        apu_waddr_i,
   output logic [ADDR_W-1:0]        apu_waddr_o,
   output logic                     apu_wvalid_o,
   output logic                     apu_multicycle_o,
   output logic                     apu_singlecycle_o,
   output logic                     active_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     stall_o,
   input  logic                     is_decoding_i,
   input  logic [N_RD*ADDR_W-1:0]   read_regs_i,
   input  logic [N_RD-1:0]          read_regs_valid_i,
   output logic                     read_dep_o,
   input  logic [N_WR*ADDR_W-1:0]   write_regs_i,
   input  logic [N_WR-1:0]          write_regs_valid_i,
   output logic                     write_dep_o,
   output logic                     perf_type_o,
   output logic                     perf_cont_o,
   output logic                     perf_full_o,
   output logic                     err_o,
   output logic                     apu_master_req_o,
   output logic                     apu_master_ready_o,
   input  logic                     apu_master_gnt_i,
   input  logic                     apu_master_valid_i
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   apu_lat_e                     r_last_lat;
   logic                         r_err;

   apu_lat_e                     w_lat;
   logic [CNT_W-1:0]             w_cnt;
   logic                         w_active;
   logic                         w_full;
   logic                         w_stall_type;
   logic                         w_stall_full;
   logic                         w_stall_nack;
   logic                         w_valid_req;
   logic                         w_ret_req;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_req_live;
   logic [ADDR_W-1:0]            w_head;
   logic [DEPTH-1:0]             w_live;
   logic [DEPTH-1:0][ADDR_W-1:0] w_addr;
   logic [N_RD-1:0]              w_rd_hit;
   logic [N_WR-1:0]              w_wr_hit;

   assign w_lat    = apu_lat_e'(apu_lat_i);
   assign w_active = (w_cnt != '0);
   assign w_full   = (w_cnt == CNT_W'(DEPTH));

   // Full stall deliberately ignores a coinciding pop so that the response
   // valid never feeds combinationally into the request.
   assign w_stall_type = enable_i & w_active & lat_conflict(w_lat, r_last_lat);
   assign w_stall_full = enable_i & w_full;
   assign w_valid_req  = enable_i & ~w_stall_type & ~w_stall_full;
   assign w_stall_nack = w_valid_req & ~apu_master_gnt_i;

   // Empty queue and a response in the same cycle as the request: the result
   // is for this very request, so it bypasses the queue.
   assign w_ret_req = w_valid_req & apu_master_valid_i & ~w_active;
   assign w_pop     = apu_master_valid_i & w_active;
   assign w_push    = w_valid_req & apu_master_gnt_i & ~w_ret_req;

   riscv_nn_apu_inflight_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_queue (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (w_push),
      .pop_i       (w_pop),
      .waddr_i     (apu_waddr_i),
      .head_addr_o (w_head),
      .count_o     (w_cnt),
      .live_o      (w_live),
      .addr_o      (w_addr)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_lat <= LAT_MULTI;
         r_err      <= 1'b0;
      end else begin
         if (w_valid_req)
            r_last_lat <= w_lat;
         if (apu_master_valid_i && !w_active && !w_valid_req)
            r_err <= 1'b1;
      end
   end

   always_comb begin
      apu_waddr_o = '0;
      if (w_ret_req)
         apu_waddr_o = apu_waddr_i;
      else if (w_pop)
         apu_waddr_o = w_head;
   end

   // The request in EX counts as outstanding unless it returns right away.
   assign w_req_live = w_valid_req & ~w_ret_req;

   for (genvar g = 0; g < N_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic [DEPTH-1:0]  w_m;
      assign w_a = read_regs_i[g*ADDR_W +: ADDR_W];
      for (genvar e = 0; e < DEPTH; e++) begin : g_ent
         assign w_m[e] = w_live[e] & (w_addr[e] == w_a);
      end
      assign w_rd_hit[g] = read_regs_valid_i[g] &
                           ((|w_m) | (w_req_live & (apu_waddr_i == w_a)));
   end

   for (genvar g = 0; g < N_WR; g++) begin : g_wr
      logic [ADDR_W-1:0] w_a;
      logic [DEPTH-1:0]  w_m;
      assign w_a = write_regs_i[g*ADDR_W +: ADDR_W];
      for (genvar e = 0; e < DEPTH; e++) begin : g_ent
         assign w_m[e] = w_live[e] & (w_addr[e] == w_a);
      end
      assign w_wr_hit[g] = write_regs_valid_i[g] &
                           ((|w_m) | (w_req_live & (apu_waddr_i == w_a)));
   end

   assign read_dep_o  = is_decoding_i & (|w_rd_hit);
   assign write_dep_o = is_decoding_i & (|w_wr_hit);

   assign apu_wvalid_o       = apu_master_valid_i;
   assign apu_multicycle_o   = (r_last_lat == LAT_LONG) | ((r_last_lat == LAT_MULTI) & w_active);
   assign apu_singlecycle_o  = ~w_active;
   assign active_o           = w_active;
   assign count_o            = w_cnt;
   assign stall_o            = w_stall_type | w_stall_full | w_stall_nack;
   assign perf_type_o        = w_stall_type;
   assign perf_cont_o        = w_stall_nack;
   assign perf_full_o        = w_stall_full;
   assign err_o              = r_err;
   assign apu_master_req_o   = w_valid_req;
   assign apu_master_ready_o = 1'b1;

endmodule

// File: tb/tb_riscv_nn_apu_disp_mq.sv
module tb_riscv_nn_apu_disp_mq;

   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int N_RD  = 3;
   localparam int N_WR  = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 en, dec, gnt, vld;
   logic [1:0]           lat;
   logic [AW-1:0]        wa;
   logic [N_RD*AW-1:0]   rr;
   logic [N_RD-1:0]      rv;
   logic [N_WR*AW-1:0]   wr;
   logic [N_WR-1:0]      wv;

   logic [AW-1:0]        waddr_o;
   logic                 wvalid_o, multi_o, single_o, active_o, stall_o;
   logic [CW-1:0]        count_o;
   logic                 rdep_o, wdep_o, ptype_o, pcont_o, pfull_o, err_o, req_o, ready_o;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: an ordered list of outstanding destinations.
   int   q[$];
   int   m_last_lat;
   bit   m_err;
   bit   m_vreq, m_ret, m_pop, m_push;

   riscv_nn_apu_disp_mq #(.DEPTH(DEPTH), .ADDR_W(AW), .N_RD(N_RD), .N_WR(N_WR)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .enable_i           (en),
      .apu_lat_i          (lat),
      .apu_waddr_i        (wa),
      .apu_waddr_o        (waddr_o),
      .apu_wvalid_o       (wvalid_o),
      .apu_multicycle_o   (multi_o),
      .apu_singlecycle_o  (single_o),
      .active_o           (active_o),
      .count_o            (count_o),
      .stall_o            (stall_o),
      .is_decoding_i      (dec),
      .read_regs_i        (rr),
      .read_regs_valid_i  (rv),
      .read_dep_o         (rdep_o),
      .write_regs_i       (wr),
      .write_regs_valid_i (wv),
      .write_dep_o        (wdep_o),
      .perf_type_o        (ptype_o),
      .perf_cont_o        (pcont_o),
      .perf_full_o        (pfull_o),
      .err_o              (err_o),
      .apu_master_req_o   (req_o),
      .apu_master_ready_o (ready_o),
      .apu_master_gnt_i   (gnt),
      .apu_master_valid_i (vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Compare every output against the model for the inputs currently applied.
   task automatic check_now();
      int  cnt;
      bit  st_type, st_full, nack, rdep, wdep;
      int  exp_wa;
      int  live[$];
      cnt     = q.size();
      st_type = en && cnt != 0 &&
                (lat == 0 || m_last_lat == 0 || int'(lat) < m_last_lat || lat == 1);
      st_full = en && cnt == DEPTH;
      m_vreq  = en && !st_type && !st_full;
      nack    = m_vreq && !gnt;
      m_ret   = m_vreq && vld && cnt == 0;
      m_pop   = vld && cnt != 0;
      m_push  = m_vreq && gnt && !m_ret;
      exp_wa  = m_ret ? int'(wa) : (m_pop ? q[0] : 0);

      live = q;
      if (m_pop) void'(live.pop_front());
      if (m_vreq && !m_ret) live.push_back(int'(wa));
      rdep = 0;
      wdep = 0;
      for (int i = 0; i < N_RD; i++)
         if (rv[i]) foreach (live[k]) if (live[k] == int'(rr[i*AW +: AW])) rdep = 1;
      for (int i = 0; i < N_WR; i++)
         if (wv[i]) foreach (live[k]) if (live[k] == int'(wr[i*AW +: AW])) wdep = 1;
      rdep = rdep && dec;
      wdep = wdep && dec;

      chk("req",    32'(req_o),    32'(m_vreq));
      chk("stall",  32'(stall_o),  32'(st_type || st_full || nack));
      chk("ptype",  32'(ptype_o),  32'(st_type));
      chk("pfull",  32'(pfull_o),  32'(st_full));
      chk("pcont",  32'(pcont_o),  32'(nack));
      chk("waddr",  32'(waddr_o),  32'(exp_wa));
      chk("wvalid", 32'(wvalid_o), 32'(vld));
      chk("count",  32'(count_o),  32'(cnt));
      chk("active", 32'(active_o), 32'(cnt != 0));
      chk("single", 32'(single_o), 32'(cnt == 0));
      chk("multi",  32'(multi_o),  32'(m_last_lat == 3 || (m_last_lat == 0 && cnt != 0)));
      chk("err",    32'(err_o),    32'(m_err));
      chk("rdep",   32'(rdep_o),   32'(rdep));
      chk("wdep",   32'(wdep_o),   32'(wdep));
      chk("ready",  32'(ready_o),  32'd1);
   endtask

   task automatic update_model();
      if (vld && q.size() == 0 && !m_vreq) m_err = 1;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(int'(wa));
      if (m_vreq) m_last_lat = int'(lat);
   endtask

   task automatic cyc(input bit e, input int l, input int a, input bit g, input bit v);
      @(negedge clk);
      en  = e;
      lat = 2'(l);
      wa  = AW'(a);
      gnt = g;
      vld = v;
      #1;
      check_now();
      update_model();
   endtask

   task automatic clear_ops();
      dec = 0; rr = '0; rv = '0; wr = '0; wv = '0;
   endtask

   task automatic model_reset();
      q.delete();
      m_last_lat = 0;
      m_err      = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 0; lat = 0; wa = 0; gnt = 0; vld = 0;
      clear_ops();
      model_reset();
      #2;
      check_now();
      @(negedge clk);
      rst_n = 1'b1;

      // Same-cycle return bypasses the queue.
      cyc(1, 1, 5, 1, 1);
      chk("ret_wa", 32'(waddr_o), 32'd5);
      cyc(0, 0, 0, 0, 0);

      // Fill with long ops, then a fifth is stalled as full.
      for (int i = 1; i <= 4; i++) cyc(1, 3, i, 1, 0);
      cyc(1, 3, 8, 1, 0);
      chk("full_stall", 32'(pfull_o), 32'd1);
      // Drain two, then pop+push together.
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 3, 7, 1, 1);
      chk("pp_wa", 32'(waddr_o), 32'd3);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);

      // Type stall plus RAW hazard against a queued destination.
      cyc(1, 3, 9, 1, 0);
      dec = 1; rr[AW-1:0] = AW'(9); rv = 3'b001;
      cyc(1, 2, 10, 1, 0);
      chk("raw", 32'(rdep_o), 32'd1);
      cyc(1, 2, 10, 1, 1);
      chk("raw_pop", 32'(rdep_o), 32'd0);
      clear_ops();

      // Withheld grant, then granted.
      cyc(1, 3, 12, 0, 0);
      cyc(1, 3, 12, 1, 0);
      cyc(0, 0, 0, 0, 1);

      // Unexpected response sets the sticky error; reset mid-queue clears all.
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 3, 20, 1, 0);
      cyc(1, 3, 21, 1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      en = 0; vld = 0;
      #1;
      model_reset();
      check_now();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with a small address space so hazards occur.
      for (int n = 0; n < 800; n++) begin
         dec = 1'($urandom_range(0, 3) != 0);
         for (int i = 0; i < N_RD; i++) rr[i*AW +: AW] = AW'($urandom_range(0, 7));
         for (int i = 0; i < N_WR; i++) wr[i*AW +: AW] = AW'($urandom_range(0, 7));
         rv = N_RD'($urandom);
         wv = N_WR'($urandom);
         cyc($urandom_range(0, 9) < 7,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 3,
             int'($urandom_range(0, 7)),
             $urandom_range(0, 4) != 0,
             $urandom_range(0, 9) < 3);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
